regfile_wb_arbiter: RTL

//  Owns the single write port of the 32x32 register file (Reg_Write/Write_Reg/Write_Data).

---
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline WB and FIFO-buffered MDU results onto the single register file write port.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Pipe_Reg_Write,
  input  logic [4:0]               Pipe_Write_Reg,
  input  logic [31:0]              Pipe_Write_Data,
  input  logic                     Mdu_Valid,
  output logic                     Mdu_Ready,
  input  logic [4:0]               Mdu_Write_Reg,
  input  logic [31:0]              Mdu_Write_Data,
  input  logic [4:0]               Query_Reg,
  output logic                     Query_Pending,
  output logic                     Reg_Write,
  output logic [4:0]               Write_Reg,
  output logic [31:0]              Write_Data,
  output logic                     Pipe_Stall,
  output logic [$clog2(DEPTH):0]   Fifo_Count,
  output logic                     Waw_Error
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0] dest [DEPTH];
  logic [31:0] data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [SW-1:0] starve;
  logic [DEPTH-1:0] q_hit, w_hit;
  logic pipe_wr, pop, push;
  assign Mdu_Ready = count != (AW+1)'(DEPTH);
  assign pipe_wr = Pipe_Reg_Write && Pipe_Write_Reg != 5'd0;
  assign pop = !pipe_wr && count != '0;
  assign push = Mdu_Valid && Mdu_Ready && Mdu_Write_Reg != 5'd0;
  assign Fifo_Count = count;
  assign Query_Pending = Query_Reg != 5'd0 && |q_hit;
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      logic [AW-1:0] off;
      logic valid;
      assign off = AW'(i) - rd_ptr;
      assign valid = {1'b0, off} < count;
      assign q_hit[i] = valid && dest[i] == Query_Reg;
      assign w_hit[i] = valid && dest[i] == Pipe_Write_Reg;
    end
  endgenerate
  always_ff @(posedge Clk) begin
    if (push) begin
      dest[wr_ptr] <= Mdu_Write_Reg;
      data[wr_ptr] <= Mdu_Write_Data;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      starve <= '0;
      Reg_Write <= 1'b0;
      Write_Reg <= '0;
      Write_Data <= '0;
      Pipe_Stall <= 1'b0;
      Waw_Error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      Reg_Write <= pipe_wr || pop;
      if (pipe_wr) begin
        Write_Reg <= Pipe_Write_Reg;
        Write_Data <= Pipe_Write_Data;
      end else if (pop) begin
        Write_Reg <= dest[rd_ptr];
        Write_Data <= data[rd_ptr];
      end
      // saturates so a long stall cannot wrap the counter back below the limit
      starve <= (count == '0 || pop) ? '0 : (starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
      Pipe_Stall <= (count == '0) ? 1'b0 : (starve == SW'(STARVE_LIMIT)) ? 1'b1 : Pipe_Stall;
      Waw_Error <= Waw_Error || (pipe_wr && |w_hit);
    end
  end
endmodule
